fpu_mul_div_sequencer: RTL and testbench
========================================

# fpu_mul_div_sequencer

Request-side front end for the iterative half-precision multiply/divide unit. It accepts operations over a valid/ready request channel, loads and starts the unit, waits for the unit's `done`, and returns result and overflow/underflow flags over a valid/ready response channel. It sits between the FPU issue logic and the multiply/divide unit and holds one operation in flight. A cycle timeout ensures a stalled unit cannot hang the pipeline.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles to wait for `unit_done` before aborting with the timeout code.
- `TAG_W`, 4: width of the request tag that is echoed on the response.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_x`, `req_y`  in  16 each  IEEE half-precision operands.
- `req_op`  in  1  0 = multiply, 1 = divide (`x / y`).
- `req_tag`  in  TAG_W  opaque tag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  16  half-precision result.
- `rsp_ofuf`  out  2  00 ok, 01 underflow, 10 overflow/divide-by-zero, 11 timeout.
- `rsp_tag`  out  TAG_W  tag of the completed request.
- `unit_x`, `unit_y`  out  16 each  operands to the unit; held stable for the whole operation.
- `unit_mulDiv`  out  1  op select to the unit.
- `unit_reset`  out  1  active-high load/start pulse to the unit.
- `unit_done`, `unit_result[15:0]`, `unit_ofuf[1:0]`  in  status from the unit.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, register x, y, op and tag into `unit_x`, `unit_y`, `unit_mulDiv` and the tag register, then go to LOAD.
- **LOAD**
  - Lasts exactly one cycle.
  - `unit_reset` = 1 (registered output). The unit samples its operands and clears its `done`.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - `unit_reset` = 0; the counter increments every cycle.
  - If `unit_done` = 1: capture `unit_ofuf`. Capture `rsp_result` as `unit_result` when `unit_ofuf` = 00, else 16'h0000. Go to RESP.
  - Else, if the counter reaches `TIMEOUT_CYCLES`: `rsp_ofuf` = 11, `rsp_result` = 0, go to RESP.
  - If `unit_done` and the timeout occur in the same cycle, `unit_done` wins.
- **RESP**
  - `rsp_valid` = 1; the payload is held stable until `rsp_ready`.
  - On handshake, go to IDLE.
  - `req_ready` stays 0; a new request is accepted no earlier than the cycle after the response handshake.
- `unit_x`, `unit_y` and `unit_mulDiv` change only on request acceptance. They are never changed while the unit is running.
- Reset outputs:
  - `req_ready` = 0 and `rsp_valid` = 0.
  - `rsp_result`, `rsp_ofuf`, `rsp_tag` = 0.
  - `unit_x`, `unit_y`, `unit_mulDiv` = 0.
  - `unit_reset` = 1 (the unit is held in reset).
  - State = IDLE; `req_ready` rises in the first cycle after `reset` deasserts.
- Reset mid-operation (LOAD, WAIT or RESP) abandons the operation. No response is produced and any pending response is dropped.
- `unit_done` is ignored outside WAIT.

## Timing
- Request accepted at edge N: LOAD during cycle N+1, WAIT from N+2.
- `unit_done` seen high in cycle N+2+k gives `rsp_valid` high from cycle N+3+k.
- Minimum request-to-response latency is 3 cycles (k = 0).
- Timeout response occurs at `TIMEOUT_CYCLES` + 3 cycles after acceptance.
- Back-to-back throughput: one operation per latency + 1 cycles (the IDLE turnaround).
- Counter width is clog2(`TIMEOUT_CYCLES` + 1). The counter saturates and never wraps.

## Structure
- Shared package `fpu_seq_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT, RESP);
  - the OFUF constants OFUF_OK = 2'b00, OFUF_UF = 2'b01, OFUF_OF = 2'b10, OFUF_TMO = 2'b11.
- One sub-module, `seq_timeout_counter`: clear, enable, saturating count, `expired` flag. It is parameterized by `TIMEOUT_CYCLES`.
- Everything else lives in a single FSM module.

## Test plan
The bench uses a behavioural unit stub with programmable latency and programmable result/OFUF.
- **Normal multiply.** Request x = 16'h3C00, y = 16'h4000, op = 0, tag = 5; stub answers 16'h4000 / 00 after 4 cycles.
  - `unit_reset` high for exactly one cycle; `unit_x`/`unit_y` stable throughout.
  - Response 16'h4000, OFUF 00, tag 5, arriving 7 cycles after acceptance.
- **Divide by zero.** Request x = 16'h3C00, y = 16'h0000, op = 1; stub returns OFUF 10 with garbage result 16'hABCD.
  - `rsp_result` = 16'h0000, `rsp_ofuf` = 10.
- **Timeout.** Stub never asserts done, `TIMEOUT_CYCLES` = 64.
  - `rsp_ofuf` = 11, result 0, `rsp_valid` rising 67 cycles after acceptance.
  - A new request then completes normally.
- **Response backpressure.** Hold `rsp_ready` = 0 for 10 cycles after `rsp_valid`.
  - Payload stable throughout; `req_ready` = 0 throughout.
  - Handshake on release; `req_ready` = 1 in the following cycle.
- **Reset mid-WAIT.** Drive `reset` = 0 for one cycle during WAIT.
  - All outputs at their reset values the next cycle, `unit_reset` = 1.
  - No `rsp_valid` for the abandoned request; `req_ready` = 1 after release.
- **Done/timeout collision.** Stub asserts done in exactly the cycle the counter expires.
  - The response carries the stub's OFUF 00 and its result, not 11.

Source files
------------

// File: rtl/fpu_mul_div_sequencer_pkg.sv
// Shared types and status codes for the multiply/divide request sequencer.
// No logic here; imported by the interface, the counter and the FSM.
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } seq_state_t;

    typedef logic [15:0] half_t;

    localparam logic [1:0] OFUF_OK  = 2'b00;
    localparam logic [1:0] OFUF_UF  = 2'b01;
    localparam logic [1:0] OFUF_OF  = 2'b10;
    localparam logic [1:0] OFUF_TMO = 2'b11;

endpackage

// File: rtl/fpu_mul_div_sequencer_if.sv
// Request and response valid/ready channels between the FPU issue logic and the sequencer.
// The slave modport is the sequencer side; the master modport is the issuer/consumer side.
interface fpu_mul_div_sequencer_if #(
    parameter int TAG_W = 4
);
    import fpu_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    half_t            req_x;
    half_t            req_y;
    logic             req_op;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    half_t            rsp_result;
    logic [1:0]       rsp_ofuf;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req_valid, req_x, req_y, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_ofuf, rsp_tag
    );

    modport master (
        output req_valid, req_x, req_y, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_ofuf, rsp_tag
    );

endinterface

// File: rtl/fpu_mul_div_sequencer_timeout.sv
// Saturating wait-cycle counter; expired is high while the count equals TIMEOUT_CYCLES.
// Clear has priority over enable; the count holds at the limit and never wraps.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import fpu_seq_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fpu_mul_div_sequencer.sv
// One-in-flight front end for the iterative half-precision mul/div unit: accept, load, wait, respond.
// Minimum 3-cycle request-to-response latency; response held until rsp_ready, no new request meanwhile.
module fpu_mul_div_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fpu_mul_div_sequencer_if.slave bus,
    output logic [15:0]            unit_x,
    output logic [15:0]            unit_y,
    output logic                   unit_mulDiv,
    output logic                   unit_reset,
    input  logic                   unit_done,
    input  logic [15:0]            unit_result,
    input  logic [1:0]             unit_ofuf
);
    import fpu_seq_pkg::*;

    seq_state_t       state_q, state_d;
    logic             cnt_clear, cnt_en, expired;
    logic [TAG_W-1:0] tag_q;
    half_t            result_q;
    logic [1:0]       ofuf_q;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = LOAD;
            LOAD: begin
                cnt_clear = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (unit_done || expired) state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            unit_x      <= '0;
            unit_y      <= '0;
            unit_mulDiv <= 1'b0;
            unit_reset  <= 1'b1;
            tag_q       <= '0;
            result_q    <= '0;
            ofuf_q      <= OFUF_OK;
        end else begin
            state_q    <= state_d;
            unit_reset <= (state_d == LOAD);
            if ((state_q == IDLE) && bus.req_valid) begin
                unit_x      <= bus.req_x;
                unit_y      <= bus.req_y;
                unit_mulDiv <= bus.req_op;
                tag_q       <= bus.req_tag;
            end
            // A done arriving on the expiry cycle still reports the unit's status.
            if (state_q == WAIT) begin
                if (unit_done) begin
                    ofuf_q   <= unit_ofuf;
                    result_q <= (unit_ofuf == OFUF_OK) ? unit_result : 16'h0000;
                end else if (expired) begin
                    ofuf_q   <= OFUF_TMO;
                    result_q <= 16'h0000;
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE) && reset;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = result_q;
    assign bus.rsp_ofuf   = ofuf_q;
    assign bus.rsp_tag    = tag_q;

endmodule

// File: tb/tb_fpu_mul_div_sequencer.sv
// Bench for fpu_mul_div_sequencer: unit stub with programmable latency/result, vector table,
// randomized operations against a behavioural model, and reset/backpressure sequences.
module tb_fpu_mul_div_sequencer;
    import fpu_seq_pkg::*;

    localparam int TMO   = 64;
    localparam int TAG_W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpu_mul_div_sequencer_if #(.TAG_W(TAG_W)) bus();

    logic [15:0] unit_x, unit_y, unit_result;
    logic        unit_mulDiv, unit_reset, unit_done;
    logic [1:0]  unit_ofuf;

    fpu_mul_div_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .TAG_W         (TAG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .unit_x      (unit_x),
        .unit_y      (unit_y),
        .unit_mulDiv (unit_mulDiv),
        .unit_reset  (unit_reset),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .unit_ofuf   (unit_ofuf)
    );

    // Unit stub: done rises lat cycles into the wait phase unless hung.
    int          stub_lat  = 0;
    bit          stub_hang = 1'b1;
    logic [15:0] stub_res  = 16'h0;
    logic [1:0]  stub_ofuf = 2'b00;
    int          stub_cnt  = 0;

    always @(posedge clk) begin
        if (unit_reset) stub_cnt <= 0;
        else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
    end

    assign unit_done   = !unit_reset && !stub_hang && (stub_cnt >= stub_lat);
    assign unit_result = stub_res;
    assign unit_ofuf   = stub_ofuf;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response predicted from the operation rules alone.
    function automatic void model(input int lat, input bit hang, input logic [15:0] sres,
                                  input logic [1:0] sofuf, output logic [15:0] eres,
                                  output logic [1:0] eofuf, output int elat);
        if (!hang && lat <= TMO) begin
            eres  = (sofuf == 2'b00) ? sres : 16'h0000;
            eofuf = sofuf;
            elat  = lat + 3;
        end else begin
            eres  = 16'h0000;
            eofuf = 2'b11;
            elat  = TMO + 3;
        end
    endfunction

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic op,
                         input logic [3:0] tag, input int lat, input bit hang,
                         input logic [15:0] sres, input logic [1:0] sofuf, input int bp,
                         input logic [15:0] eres, input logic [1:0] eofuf, input int elat);
        int  n, t0, pulses, lat_seen;
        bit  stable, hold;
        stub_lat  = lat;
        stub_hang = hang;
        stub_res  = sres;
        stub_ofuf = sofuf;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_op    = op;
        bus.req_tag   = tag;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_x     = ~x;
        bus.req_y     = ~y;
        t0 = cyc;
        check("load_pulse", 32'(unit_reset), 32'd1);
        pulses   = 0;
        stable   = 1'b1;
        lat_seen = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) begin
                lat_seen = cyc - t0 + 1;
                break;
            end
            if (unit_reset) pulses++;
            if (unit_x !== x || unit_y !== y || unit_mulDiv !== op || bus.req_ready !== 1'b0)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        check("rsp_latency", 32'(lat_seen), 32'(elat));
        check("unit_reset_pulses", 32'(pulses), 32'd1);
        check("operands_stable", 32'(stable), 32'd1);
        if (lat_seen > 0) begin
            check("rsp_result", 32'(bus.rsp_result), 32'(eres));
            check("rsp_ofuf", 32'(bus.rsp_ofuf), 32'(eofuf));
            check("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
            hold = 1'b1;
            for (int i = 0; i < bp; i++) begin
                if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== eres || bus.rsp_ofuf !== eofuf ||
                    bus.rsp_tag !== tag || bus.req_ready !== 1'b0)
                    hold = 1'b0;
                @(posedge clk); #1;
            end
            if (bp > 0) check("bp_hold", 32'(hold), 32'd1);
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
            check("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        end
    endtask

    typedef struct {
        logic [15:0] x, y;
        logic        op;
        logic [3:0]  tag;
        int          lat;
        bit          hang;
        logic [15:0] sres;
        logic [1:0]  sofuf;
        int          bp;
        logic [15:0] eres;
        logic [1:0]  eofuf;
        int          elat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] rx, ry, rres, eres;
        logic [1:0]  rofuf, eofuf;
        logic [3:0]  rtag;
        logic        rop;
        int          rlat, rbp, elat;
        bit          rhang, seen;

        vecs[0] = '{16'h3C00, 16'h4000, 1'b0, 4'd5,  4,  1'b0, 16'h4000, 2'b00, 0,  16'h4000, 2'b00, 7};
        vecs[1] = '{16'h3C00, 16'h0000, 1'b1, 4'd6,  2,  1'b0, 16'hABCD, 2'b10, 0,  16'h0000, 2'b10, 5};
        vecs[2] = '{16'h1234, 16'h5678, 1'b0, 4'd7,  0,  1'b1, 16'hFFFF, 2'b00, 0,  16'h0000, 2'b11, 67};
        vecs[3] = '{16'h4200, 16'h3C00, 1'b1, 4'd8,  0,  1'b0, 16'h4200, 2'b00, 0,  16'h4200, 2'b00, 3};
        vecs[4] = '{16'h4400, 16'h4400, 1'b0, 4'd9,  3,  1'b0, 16'h4C00, 2'b00, 10, 16'h4C00, 2'b00, 6};
        vecs[5] = '{16'h3800, 16'h3800, 1'b0, 4'd10, 64, 1'b0, 16'h3400, 2'b00, 0,  16'h3400, 2'b00, 67};
        vecs[6] = '{16'h0400, 16'h7800, 1'b1, 4'd11, 1,  1'b0, 16'h1111, 2'b01, 2,  16'h0000, 2'b01, 4};

        bus.req_valid = 1'b0;
        bus.req_x     = 16'h0;
        bus.req_y     = 16'h0;
        bus.req_op    = 1'b0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rst_rsp_ofuf", 32'(bus.rsp_ofuf), 32'd0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst_unit_x", 32'(unit_x), 32'd0);
        check("rst_unit_y", 32'(unit_y), 32'd0);
        check("rst_unit_muldiv", 32'(unit_mulDiv), 32'd0);
        check("rst_unit_reset", 32'(unit_reset), 32'd1);
        reset = 1'b1;
        #1;
        check("req_ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].tag, vecs[i].lat, vecs[i].hang,
                  vecs[i].sres, vecs[i].sofuf, vecs[i].bp, vecs[i].eres, vecs[i].eofuf, vecs[i].elat);

        // Reset pulse while the unit is running.
        stub_hang     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_x     = 16'h5555;
        bus.req_y     = 16'hAAAA;
        bus.req_op    = 1'b1;
        bus.req_tag   = 4'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_unit_reset", 32'(unit_reset), 32'd1);
        check("midrst_unit_x", 32'(unit_x), 32'd0);
        check("midrst_unit_y", 32'(unit_y), 32'd0);
        check("midrst_unit_muldiv", 32'(unit_mulDiv), 32'd0);
        check("midrst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        check("midrst_req_ready_after", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            rx    = 16'($urandom);
            ry    = 16'($urandom);
            rop   = 1'($urandom);
            rtag  = 4'($urandom);
            rlat  = int'($urandom_range(0, 70));
            rhang = ($urandom_range(0, 7) == 0);
            rres  = 16'($urandom);
            rofuf = 2'($urandom_range(0, 2));
            rbp   = int'($urandom_range(0, 3));
            model(rlat, rhang, rres, rofuf, eres, eofuf, elat);
            do_op(rx, ry, rop, rtag, rlat, rhang, rres, rofuf, rbp, eres, eofuf, elat);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
